// File: rtl/branch_resolve_queue.sv
// In-flight conditional-branch tracker: holds predicted branches from fetch, resolves them in
// order against execute outcomes, trains the PHT and raises flush/redirect on mispredicts.
module branch_resolve_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    input  logic [PC_W-1:0]          push_pc,
    input  logic                     push_pred_taken,
    output logic                     push_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [PC_W-1:0]          res_target,
    output logic                     upd_valid,
    output logic [PC_W-1:0]          upd_pc,
    output logic                     upd_taken,
    output logic                     flush,
    output logic [PC_W-1:0]          redirect_pc,
    output logic                     res_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              branch_cnt,
    output logic [15:0]              mispredict_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // Entry storage; not reset since count/pointers define what is live
    logic [PC_W-1:0] pc_mem_q   [DEPTH];
    logic            pred_mem_q [DEPTH];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic            upd_valid_q, upd_valid_d;
    logic [PC_W-1:0] upd_pc_q, upd_pc_d;
    logic            upd_taken_q, upd_taken_d;
    logic            flush_q, flush_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
    logic            res_err_q, res_err_d;
    logic [15:0]     branch_cnt_q, branch_cnt_d;
    logic [15:0]     mispredict_cnt_q, mispredict_cnt_d;

    logic            queue_full;
    logic            queue_empty;
    logic            do_push;
    logic            do_res;
    logic            mispredict;
    logic            mem_we;
    logic [PC_W-1:0] head_pc;
    logic            head_pred;

    assign queue_full  = (count_q == CntW'(DEPTH));
    assign queue_empty = (count_q == '0);
    assign head_pc     = pc_mem_q[rd_ptr_q];
    assign head_pred   = pred_mem_q[rd_ptr_q];

    always_comb begin
        do_push    = push_valid & ~queue_full;
        do_res     = res_valid & ~queue_empty;
        mispredict = do_res & (res_taken != head_pred);
        // A push coinciding with a mispredict is on the wrong path
        mem_we     = do_push & ~mispredict;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (mispredict) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_res) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (mem_we) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_res && !mem_we) begin
                count_d = count_q - 1'b1;
            end else if (mem_we && !do_res) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_comb begin
        upd_valid_d      = do_res;
        upd_pc_d         = upd_pc_q;
        upd_taken_d      = upd_taken_q;
        flush_d          = mispredict;
        redirect_pc_d    = redirect_pc_q;
        res_err_d        = res_valid & queue_empty;
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;

        if (do_res) begin
            upd_pc_d    = head_pc;
            upd_taken_d = res_taken;
            if (branch_cnt_q != 16'hFFFF) begin
                branch_cnt_d = branch_cnt_q + 16'd1;
            end
        end

        if (mispredict) begin
            redirect_pc_d = res_taken ? res_target : head_pc + PC_W'(4);
            if (mispredict_cnt_q != 16'hFFFF) begin
                mispredict_cnt_d = mispredict_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            pc_mem_q[wr_ptr_q]   <= push_pc;
            pred_mem_q[wr_ptr_q] <= push_pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            upd_valid_q      <= 1'b0;
            upd_pc_q         <= '0;
            upd_taken_q      <= 1'b0;
            flush_q          <= 1'b0;
            redirect_pc_q    <= '0;
            res_err_q        <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
            upd_valid_q      <= upd_valid_d;
            upd_pc_q         <= upd_pc_d;
            upd_taken_q      <= upd_taken_d;
            flush_q          <= flush_d;
            redirect_pc_q    <= redirect_pc_d;
            res_err_q        <= res_err_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign push_ready     = ~queue_full;
    assign upd_valid      = upd_valid_q;
    assign upd_pc         = upd_pc_q;
    assign upd_taken      = upd_taken_q;
    assign flush          = flush_q;
    assign redirect_pc    = redirect_pc_q;
    assign res_err        = res_err_q;
    assign count          = count_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus random traffic, all checked against a
// queue-based reference model of the branch tracker.
module tb_branch_resolve_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PC_W  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            push_valid;
    logic [PC_W-1:0] push_pc;
    logic            push_pred_taken;
    logic            push_ready;
    logic            res_valid;
    logic            res_taken;
    logic [PC_W-1:0] res_target;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic            flush;
    logic [PC_W-1:0] redirect_pc;
    logic            res_err;
    logic [2:0]      count;
    logic [15:0]     branch_cnt;
    logic [15:0]     mispredict_cnt;

    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .push_valid     (push_valid),
        .push_pc        (push_pc),
        .push_pred_taken(push_pred_taken),
        .push_ready     (push_ready),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .res_err        (res_err),
        .count          (count),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue entries are {pred, pc}
    logic [PC_W:0]   m_q[$];
    logic            m_upd_valid, m_upd_taken, m_flush, m_res_err;
    logic [PC_W-1:0] m_upd_pc, m_redirect_pc;
    int unsigned     m_bcnt, m_mcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int          sz;
        logic [PC_W:0] head;
        bit          mis;
        if (rst) begin
            m_q.delete();
            m_upd_valid = 0; m_upd_taken = 0; m_flush = 0; m_res_err = 0;
            m_upd_pc = '0; m_redirect_pc = '0; m_bcnt = 0; m_mcnt = 0;
            return;
        end
        sz = m_q.size();
        mis = 0;
        m_upd_valid = 0; m_flush = 0; m_res_err = 0;
        if (res_valid) begin
            if (sz == 0) begin
                m_res_err = 1;
            end else begin
                head = m_q.pop_front();
                m_upd_valid = 1;
                m_upd_pc = head[PC_W-1:0];
                m_upd_taken = res_taken;
                if (m_bcnt < 65535) m_bcnt++;
                if (res_taken != head[PC_W]) begin
                    mis = 1;
                    m_flush = 1;
                    m_redirect_pc = res_taken ? res_target : PC_W'((head[PC_W-1:0] + 32'd4) % 65536);
                    if (m_mcnt < 65535) m_mcnt++;
                    m_q.delete();
                end
            end
        end
        if (push_valid && sz < DEPTH && !mis) m_q.push_back({push_pred_taken, push_pc});
    endtask

    task automatic compare_all();
        check("count", 32'(count), 32'(m_q.size()));
        check("upd_valid", 32'(upd_valid), 32'(m_upd_valid));
        check("upd_pc", 32'(upd_pc), 32'(m_upd_pc));
        check("upd_taken", 32'(upd_taken), 32'(m_upd_taken));
        check("flush", 32'(flush), 32'(m_flush));
        check("redirect_pc", 32'(redirect_pc), 32'(m_redirect_pc));
        check("res_err", 32'(res_err), 32'(m_res_err));
        check("branch_cnt", 32'(branch_cnt), m_bcnt);
        check("mispredict_cnt", 32'(mispredict_cnt), m_mcnt);
    endtask

    task automatic step(input logic pv, input logic [PC_W-1:0] ppc, input logic pp,
                        input logic rv, input logic rt, input logic [PC_W-1:0] rtg,
                        input logic r, input bit chk);
        push_valid = pv; push_pc = ppc; push_pred_taken = pp;
        res_valid = rv; res_taken = rt; res_target = rtg; rst = r;
        #1;
        if (chk) check("push_ready", 32'(push_ready), 32'(m_q.size() < DEPTH));
        @(posedge clk);
        model_step();
        #1;
        if (chk) compare_all();
    endtask

    task automatic idle(input bit chk);
        step(0, '0, 0, 0, 0, '0, 0, chk);
    endtask

    task automatic push(input logic [PC_W-1:0] pc, input logic pred);
        step(1, pc, pred, 0, 0, '0, 0, 1);
    endtask

    task automatic resolve(input logic taken, input logic [PC_W-1:0] tgt);
        step(0, '0, 0, 1, taken, tgt, 0, 1);
    endtask

    initial begin
        logic [PC_W-1:0] rpc;
        // 1: reset
        step(0, '0, 0, 0, 0, '0, 1, 0);
        step(0, '0, 0, 0, 0, '0, 1, 1);
        check("reset_count", 32'(count), 0);
        check("reset_push_ready", 32'(push_ready), 1);

        // 2: correct taken prediction
        push(16'h0040, 1);
        resolve(1, 16'h0100);
        check("t2_upd_pc", 32'(upd_pc), 32'h40);
        check("t2_branch_cnt", 32'(branch_cnt), 1);

        // 3: mispredict on first of three; push in resolve cycle is dropped
        push(16'h0010, 1);
        push(16'h0020, 0);
        push(16'h0030, 0);
        step(1, 16'h0050, 0, 1, 0, 16'h0200, 0, 1);
        check("t3_redirect", 32'(redirect_pc), 32'h14);
        check("t3_count", 32'(count), 0);
        idle(1);

        // 4: fill, overflow drop, wrap with ordered retirement
        push(16'h1000, 1);
        push(16'h1004, 0);
        push(16'h1008, 1);
        push(16'h100C, 0);
        check("t4_full_ready", 32'(push_ready), 0);
        push(16'h1010, 1);
        resolve(1, 16'h2000);
        resolve(0, 16'h2000);
        step(1, 16'h1014, 1, 1, 1, 16'h2000, 0, 1);
        check("t4_simul_count", 32'(count), 2);
        push(16'h1018, 0);
        resolve(0, '0);
        resolve(1, '0);
        resolve(0, '0);
        check("t4_last_upd_pc", 32'(upd_pc), 32'h1018);
        idle(1);

        // 5: resolve on empty queue
        resolve(1, 16'h3000);
        check("t5_res_err", 32'(res_err), 1);
        idle(1);

        // 6: PC wrap on redirect, then reset with entries held
        push(16'hFFFE, 1);
        resolve(0, '0);
        check("t6_redirect_wrap", 32'(redirect_pc), 32'h2);
        push(16'h0100, 1);
        push(16'h0104, 1);
        push(16'h0108, 0);
        step(0, '0, 0, 0, 0, '0, 1, 1);
        check("t6_rst_flush", 32'(flush), 0);
        idle(1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rpc = PC_W'({$urandom_range(0, 16383), 2'b00});
            step($urandom_range(0, 1), rpc, $urandom_range(0, 1),
                 ($urandom_range(0, 9) < 4), $urandom_range(0, 1), PC_W'($urandom),
                 ($urandom_range(0, 199) == 0), 1);
        end

        // Counter saturation: sustained correct push+resolve at depth 1
        step(0, '0, 0, 0, 0, '0, 1, 1);
        push(16'h0400, 1);
        for (int i = 0; i < 65540; i++) begin
            step(1, 16'h0400, 1, 1, 1, 16'h0800, 0, (i % 4096) == 0);
        end
        compare_all();
        check("sat_branch_cnt", 32'(branch_cnt), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
